// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : stage record, forward-select encoding, nearest-writer search
// Revision   : 1.0
// ============================================================================
package hazard_pkg;

  localparam int REC_RA_W = 8;
  localparam int REC_T_W  = 8;
  localparam int MAX_STG  = 15;
  localparam int HIT_W    = MAX_STG + 1;
  localparam int IDX_W    = 4;

  localparam int FWD_RF = 0;
  localparam int FWD_E  = 1;
  localparam int FWD_M  = 2;
  localparam int FWD_W  = 3;

  typedef struct packed {
    logic [REC_RA_W-1:0] rs;
    logic [REC_RA_W-1:0] rt;
    logic [REC_RA_W-1:0] dst;
    logic [REC_T_W-1:0]  tnew;
    logic                md;
  } stage_rec_t;

  // Smallest stage index above the consumer with a hit; 0 when none.
  function automatic logic [IDX_W-1:0] nearest_match(input logic [HIT_W-1:0] hits,
                                                     input logic [IDX_W-1:0] consumer);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int j = MAX_STG; j >= 1; j--) begin
      if (hits[j] && (IDX_W'(j) > consumer)) idx = IDX_W'(j);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_if : decode-side hazard request and control response
// Revision             : 1.0
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int NSTG = 3,
  parameter int RA_W = 5,
  parameter int T_W  = 3
);
  localparam int FS_W = $clog2(NSTG + 1);

  logic [RA_W-1:0] d_rs;
  logic [RA_W-1:0] d_rt;
  logic [T_W-1:0]  d_tuse_rs;
  logic [T_W-1:0]  d_tuse_rt;
  logic [RA_W-1:0] d_dst;
  logic [T_W-1:0]  d_tnew;
  logic            d_md_start;
  logic            d_md_use;
  logic            flush;

  logic [FS_W-1:0] fwd_d_rs;
  logic [FS_W-1:0] fwd_d_rt;
  logic [FS_W-1:0] fwd_e_rs;
  logic [FS_W-1:0] fwd_e_rt;
  logic [FS_W-1:0] fwd_m_rt;
  logic            stall;
  logic            pc_en;
  logic            d_en;
  logic            e_clr;
  logic            md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_md_start, d_md_use, flush,
    input  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall, pc_en, d_en, e_clr, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_md_start, d_md_use, flush,
    output fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall, pc_en, d_en, e_clr, md_busy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_md_busy_counter.sv
`default_nettype none
// ============================================================================
// md_busy_counter : mult/div occupancy countdown, loads on issue into E
// Revision        : 1.0
// ============================================================================
module md_busy_counter #(
  parameter int MD_LAT = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic md_busy
);
  localparam int CNT_W = $clog2(MD_LAT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MD_LAT);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign md_busy = (count != '0);
endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : in-flight writer tracking, forwarding selects, stall/flush
// Revision          : 1.0
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTG   = 3,
  parameter int RA_W   = 5,
  parameter int T_W    = 3,
  parameter int MD_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave hz
);
  localparam int FS_W = $clog2(NSTG + 1);

  logic [RA_W-1:0] d_rs, d_rt, d_dst;
  logic [T_W-1:0]  d_tuse_rs, d_tuse_rt, d_tnew;

  stage_rec_t      recs [0:NSTG];
  logic [NSTG:0]   hit_d_rs, hit_d_rt, hit_e_rs, hit_e_rt, hit_m_rt;
  logic [FS_W-1:0] sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, sel_m_rt;
  logic            stall_rs, stall_rt, stall_md, stall, e_clr, md_load, md_busy;

  assign d_rs      = hz.d_rs;
  assign d_rt      = hz.d_rt;
  assign d_dst     = hz.d_dst;
  assign d_tuse_rs = hz.d_tuse_rs;
  assign d_tuse_rt = hz.d_tuse_rt;
  assign d_tnew    = hz.d_tnew;

  // Index 0 holds the decode-stage instruction so stage k always reads recs[k-1].
  assign recs[0] = '{rs:   REC_RA_W'(d_rs),
                     rt:   REC_RA_W'(d_rt),
                     dst:  REC_RA_W'(d_dst),
                     tnew: REC_T_W'(d_tnew),
                     md:   hz.d_md_start};

  assign hit_d_rs[0] = 1'b0;
  assign hit_d_rt[0] = 1'b0;
  assign hit_e_rs[0] = 1'b0;
  assign hit_e_rt[0] = 1'b0;
  assign hit_m_rt[0] = 1'b0;

  for (genvar k = 1; k <= NSTG; k++) begin : g_stage
    stage_rec_t rec_d, rec_q;

    if (k == 1) begin : g_head
      assign rec_d = e_clr ? '0 : recs[0];
    end else begin : g_tail
      always_comb begin
        rec_d = recs[k-1];
        if (recs[k-1].tnew != '0) rec_d.tnew = recs[k-1].tnew - REC_T_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) rec_q <= '0;
      else       rec_q <= rec_d;
    end

    assign recs[k] = rec_q;

    assign hit_d_rs[k] = (recs[k].dst == recs[0].rs) && (recs[0].rs != '0);
    assign hit_d_rt[k] = (recs[k].dst == recs[0].rt) && (recs[0].rt != '0);
    assign hit_e_rs[k] = (recs[k].dst == recs[FWD_E].rs) && (recs[FWD_E].rs != '0);
    assign hit_e_rt[k] = (recs[k].dst == recs[FWD_E].rt) && (recs[FWD_E].rt != '0);
    assign hit_m_rt[k] = (recs[k].dst == recs[FWD_M].rt) && (recs[FWD_M].rt != '0);
  end

  assign sel_d_rs = FS_W'(nearest_match(HIT_W'(hit_d_rs), IDX_W'(FWD_RF)));
  assign sel_d_rt = FS_W'(nearest_match(HIT_W'(hit_d_rt), IDX_W'(FWD_RF)));
  assign sel_e_rs = FS_W'(nearest_match(HIT_W'(hit_e_rs), IDX_W'(FWD_E)));
  assign sel_e_rt = FS_W'(nearest_match(HIT_W'(hit_e_rt), IDX_W'(FWD_E)));
  assign sel_m_rt = FS_W'(nearest_match(HIT_W'(hit_m_rt), IDX_W'(FWD_M)));

  // A nearest writer still computing masks older copies; the value is re-forwarded later.
  assign hz.fwd_d_rs = (sel_d_rs != '0 && recs[sel_d_rs].tnew == '0) ? sel_d_rs : FS_W'(FWD_RF);
  assign hz.fwd_d_rt = (sel_d_rt != '0 && recs[sel_d_rt].tnew == '0) ? sel_d_rt : FS_W'(FWD_RF);
  assign hz.fwd_e_rs = (sel_e_rs != '0 && recs[sel_e_rs].tnew == '0) ? sel_e_rs : FS_W'(FWD_RF);
  assign hz.fwd_e_rt = (sel_e_rt != '0 && recs[sel_e_rt].tnew == '0) ? sel_e_rt : FS_W'(FWD_RF);
  assign hz.fwd_m_rt = (sel_m_rt != '0 && recs[sel_m_rt].tnew == '0) ? sel_m_rt : FS_W'(FWD_RF);

  assign stall_rs = (sel_d_rs != '0) && (recs[sel_d_rs].tnew > REC_T_W'(d_tuse_rs));
  assign stall_rt = (sel_d_rt != '0) && (recs[sel_d_rt].tnew > REC_T_W'(d_tuse_rt));
  assign stall_md = hz.d_md_use && (md_busy || recs[FWD_E].md);
  assign stall    = stall_rs | stall_rt | stall_md;
  assign e_clr    = stall | hz.flush;
  assign md_load  = hz.d_md_start & ~e_clr;

  md_busy_counter #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (md_load),
    .md_busy (md_busy)
  );

  assign hz.stall   = stall;
  assign hz.pc_en   = ~stall;
  assign hz.d_en    = ~stall;
  assign hz.e_clr   = e_clr;
  assign hz.md_busy = md_busy;
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard : directed hazard sequences with queued expectations
// Revision             : 1.0
// ============================================================================
module tb_hazard_scoreboard;
  localparam int NSTG   = 3;
  localparam int RA_W   = 5;
  localparam int T_W    = 3;
  localparam int MD_LAT = 5;

  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  exp_t e;
  logic [14:0] obs;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NSTG(NSTG), .RA_W(RA_W), .T_W(T_W)) hz ();

  hazard_scoreboard #(
    .NSTG(NSTG), .RA_W(RA_W), .T_W(T_W), .MD_LAT(MD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, stall, pc_en, d_en, e_clr, md_busy}
  task automatic cyc(input string nm, input int rs, rt, dst, tnew, tu_rs, tu_rt,
                     input bit mds, mdu, fl, rst,
                     input int fdrs, fdrt, fers, fert, fmrt, input bit st, ec, busy);
    exp_t x;
    hz.d_rs = 5'(rs);  hz.d_rt = 5'(rt);  hz.d_dst = 5'(dst);
    hz.d_tnew = 3'(tnew);  hz.d_tuse_rs = 3'(tu_rs);  hz.d_tuse_rt = 3'(tu_rt);
    hz.d_md_start = mds;  hz.d_md_use = mdu;  hz.flush = fl;  reset = rst;
    x.name = nm;
    x.v = {2'(fdrs), 2'(fdrt), 2'(fers), 2'(fert), 2'(fmrt), st, ~st, ~st, ec, busy};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        obs = {hz.fwd_d_rs, hz.fwd_d_rt, hz.fwd_e_rs, hz.fwd_e_rt, hz.fwd_m_rt,
               hz.stall, hz.pc_en, hz.d_en, hz.e_clr, hz.md_busy};
        n_tests++;
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b required %b (fdrs fdrt fers fert fmrt st pc d eclr busy)",
                   e.name, obs, e.v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    hz.d_rs = '0; hz.d_rt = '0; hz.d_dst = '0; hz.d_tnew = '0;
    hz.d_tuse_rs = '0; hz.d_tuse_rt = '0;
    hz.d_md_start = 1'b0; hz.d_md_use = 1'b0; hz.flush = 1'b0;
    @(posedge clk);
    #1;
    //   name          rs rt dst tn tur tut mds mdu fl rst  fdrs fdrt fers fert fmrt st ec bsy
    cyc("reset",        0, 0, 0, 0, 0, 0,  0,  0, 0, 1,   0, 0, 0, 0, 0,  0, 0, 0);
    // ALU producer followed by a dependent ALU reader
    cyc("addu3",        1, 2, 3, 1, 1, 1,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("dep_addu",     3, 0, 7, 1, 1, 1,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("dep_e_fwd",    0, 0, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 2, 0, 0,  0, 0, 0);
    // load then branch consuming the load in D
    cyc("lw4",         29, 0, 4, 2, 1, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("beq_stall1",   4, 7, 0, 0, 0, 0,  0,  0, 0, 0,   0, 3, 0, 0, 0,  1, 1, 0);
    cyc("beq_stall2",   4, 7, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 0);
    cyc("beq_go",       4, 7, 0, 0, 0, 0,  0,  0, 0, 0,   3, 0, 0, 0, 0,  0, 0, 0);
    // two writers of $5: the younger busy one must mask the older ready one
    cyc("w5_a",         1, 2, 5, 1, 1, 1,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("w5_b",         6, 0, 5, 2, 1, 1,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("r5_d_young",   5, 5, 8, 1, 2, 2,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("r5_e_young",   0, 0, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("r5_m_fwd",     0, 0, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0, 3,  0, 0, 0);
    // mult then mfhi
    cyc("mult",         8, 9, 0, 0, 0, 0,  1,  1, 0, 0,   3, 0, 0, 0, 0,  0, 0, 0);
    cyc("mfhi_s1",      0, 0,10, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1);
    cyc("mfhi_s2",      0, 0,10, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1);
    cyc("mfhi_s3",      0, 0,10, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1);
    cyc("mfhi_s4",      0, 0,10, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1);
    cyc("mfhi_s5",      0, 0,10, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1);
    cyc("mfhi_go",      0, 0,10, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    // flushed producer must leave no trace
    cyc("flush_addu6",  1, 2, 6, 1, 1, 1,  0,  0, 1, 0,   0, 0, 0, 0, 0,  0, 1, 0);
    cyc("r6_after_fl",  6,10, 0, 0, 0, 0,  0,  0, 0, 0,   0, 2, 0, 0, 0,  0, 0, 0);
    cyc("r6_e_fwd",     0, 0, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 3, 0,  0, 0, 0);
    // flush together with a load-use stall, then reset mid-stall
    cyc("lw11",         0, 0,11, 2, 1, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("fl_and_stall",11, 0, 0, 0, 0, 0,  0,  0, 1, 0,   0, 0, 0, 0, 0,  1, 1, 0);
    cyc("stall_rst",   11, 0, 0, 0, 0, 0,  0,  0, 0, 1,   0, 0, 0, 0, 0,  1, 1, 0);
    cyc("after_rst1",  11, 0, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    // reset in the middle of a multiply
    cyc("mult2",        1, 2, 0, 0, 0, 0,  1,  1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("mult_rst",     0, 0, 0, 0, 0, 0,  0,  0, 0, 1,   0, 0, 0, 0, 0,  0, 0, 1);
    cyc("mfhi_free",    0, 0, 3, 1, 0, 0,  0,  1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("indep_a",      1, 2, 4, 1, 1, 1,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("indep_b",      4, 3, 5, 1, 1, 1,  0,  0, 0, 0,   0, 2, 0, 0, 0,  0, 0, 0);
    cyc("indep_e_fwd",  0, 0, 0, 0, 0, 0,  0,  0, 0, 0,   0, 0, 2, 3, 0,  0, 0, 0);
    // tnew longer than the tracked pipe
    cyc("long_tnew",    0, 0,12, 5, 0, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);
    cyc("long_s1",     12, 0, 0, 0, 3, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 0);
    cyc("long_s2",     12, 0, 0, 0, 3, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 0);
    cyc("long_go",     12, 0, 0, 0, 3, 0,  0,  0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order MIPS pipeline: tracks in-flight register writers over a configurable number of post-decode stages, produces per-operand forwarding selects and a stall/bubble decision. Adds a multi-cycle multiply/divide busy tracker and an external flush. Sits beside the decode stage; datapath muxes and pipeline-register enables are driven from its outputs.

## Interface
- `NSTG`, 3: number of tracked stages after D (1=E, 2=M, 3=W, …), ≥2
- `RA_W`, 5: register address width
- `T_W`, 3: width of t_use/t_new fields
- `MD_LAT`, 5: cycles the mult/div unit stays busy after a start enters E, ≥1
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `d_rs`, `d_rt` in RA_W: D-stage source registers (0 = unused)
- `d_tuse_rs`, `d_tuse_rt` in T_W: cycles from D until each source is consumed
- `d_dst` in RA_W: D-stage destination (0 = none)
- `d_tnew` in T_W: cycles after entering E until the result is forwardable
- `d_md_start` in 1: D instruction starts a mult/div
- `d_md_use` in 1: D instruction reads HI/LO or starts a mult/div
- `flush` in 1: kill the D instruction (it enters E as a bubble)
- `fwd_d_rs`, `fwd_d_rt` out clog2(NSTG+1): D operand source; 0 = register file, k = stage k
- `fwd_e_rs`, `fwd_e_rt` out clog2(NSTG+1): E operand source; 0 = pipeline value, k ∈ 2..NSTG
- `fwd_m_rt` out clog2(NSTG+1): M store-data source; 0 = pipeline value, k ∈ 3..NSTG
- `stall` out 1: hazard detected
- `pc_en`, `d_en` out 1: `~stall`
- `e_clr` out 1: `stall | flush`
- `md_busy` out 1: mult/div counter nonzero

## Operation
- Record per stage k: `{rs, rt, dst, tnew}`. A bubble is all zero.
- Shift each cycle:
  - For k ≥ 1, stage k+1 ← stage k, with `tnew = max(tnew-1, 0)`.
  - Stage 1 (E) ← `{d_rs, d_rt, d_dst, d_tnew}`, or a bubble if `e_clr`.
  - The last stage's record is dropped.
- Match rule for consumer stage s and source r:
  - Only stages j > s are candidates.
  - Candidate condition: `dst_j == r` and `r != 0`.
  - The nearest (smallest j) candidate wins.
- Forward select:
  - If the winning j has `tnew_j == 0`, output j.
  - Otherwise output 0. Never fall through to an older stage. The value is re-forwarded downstream.
- Stall rule, per D source with `r != 0`: stall if the winning j has `tnew_j > d_tuse`.
- Mult/div stall: stall if `d_md_use` and (`md_busy` or stage-1 record carries a pending md start).
- Mult/div counter:
  - Loads `MD_LAT` on the cycle a non-cleared `d_md_start` enters E.
  - Otherwise decrements to 0 and saturates there.
  - A load while nonzero cannot occur, because the mult/div stall prevents it.
- `flush` and `stall` together: bubble into E, D held (`d_en=0`). Flush does not override the hold.
- Width: all `tnew` arithmetic saturates at 0. `d_tnew` > NSTG is legal, and the record stays busy until it leaves.

## Timing
- `fwd_*`, `stall`, `pc_en`, `d_en`, `e_clr` are combinational from the current records and D inputs: zero-cycle latency.
- Records and the counter update on `posedge clk`.
- A producer entering E at cycle t with `d_tnew=n` is forwardable from stage j = n+1 at cycle t+n.
- `reset` (any cycle, including mid-stall or mid-mult/div) clears all records and the counter on the next edge. After reset: `stall=0`, `pc_en=d_en=1`, `e_clr=0` (with `flush=0`), all `fwd_*=0`, `md_busy=0`.
- Reset takes priority over shift and load.

## Structure
- Package `hazard_pkg` holds:
  - the stage-record struct
  - forward-select encoding constants (`FWD_RF=0`, stage indices)
  - a `nearest_match` function shared by the D/E/M select logic
- One sub-module: `md_busy_counter`, with load/decrement/saturate logic and output `md_busy`.
- Record shift and match logic stay in the top, generated over `NSTG`.

## Test plan
- `addu $3` (d_tnew=1), then dependent `addu` reading `$3` (tuse=1): no stall. Next cycle `fwd_d_rs=0`, `fwd_e_rs=2`.
- `lw $4` (d_tnew=2), then `beq` using `$4` (tuse=0):
  - `stall=1` for 2 cycles, with `e_clr=1` each cycle.
  - Third cycle: `fwd_d_rs=3`, `stall=0`.
- Two writers to `$5` back-to-back, then a reader of `$5`: select names the younger writer (stage 1/2), never the older one.
- `mult` (MD_LAT=5), then `mfhi`: `md_busy` high 5 cycles and `mfhi` stalled throughout; it issues on the cycle `md_busy` falls.
- `flush=1` with D holding `addu $6`: E record becomes a bubble, and a later reader of `$6` sees `fwd=0` and no stall.
- `reset` asserted mid-load-stall and mid-mult: next cycle all outputs return to their reset values; a subsequent independent stream runs with `stall=0`.
